adc_capture_sched: RTL and testbench

//  Capture scheduler for the multi-channel scope front end. Drains the per-channel ADC FIFOs
//  in a fixed interleaved order: one sample per enabled channel per row, Frame_Len rows per frame.

---
 rtl/adc_capture_sched.sv | 211 +++++++++++++++++++++
 tb/tb_adc_capture_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sched.sv
// adc_capture_sched: drains the per-channel ADC FIFOs in a fixed interleave
// (one sample per enabled channel per row, Frame_Len rows per frame) and
// streams the samples on a single valid/ready port tagged with the channel.
//
// Ports
//   Clk, Reset            clock and synchronous active-high reset
//   Start, Abort          arm pulse (IDLE only) / return-to-IDLE request
//   Ch_Enable, Frame_Len  frame configuration, latched on an accepted Start
//   Fifo_Empty, Fifo_Q    per-channel FIFO status and data (non-showahead)
//   Fifo_Rdreq            per-channel read strobe, at most one bit high
//   Out_Data, Out_Ch,
//   Out_Valid, Out_Last   sample stream to the upload path
//   Out_Ready             downstream accept
//   Busy, Done            status: not IDLE / one-cycle end-of-frame pulse
module adc_capture_sched #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 12,
    parameter int unsigned CH_W   = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Abort,
    input  logic [CH_NUM-1:0]        Ch_Enable,
    input  logic [LEN_W-1:0]         Frame_Len,
    input  logic [CH_NUM-1:0]        Fifo_Empty,
    input  logic [CH_NUM*DATA_W-1:0] Fifo_Q,
    output logic [CH_NUM-1:0]        Fifo_Rdreq,
    output logic [DATA_W-1:0]        Out_Data,
    output logic [CH_W-1:0]          Out_Ch,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic                     Out_Last,
    output logic                     Busy,
    output logic                     Done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CH_NUM-1:0]   mask_q, mask_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    row_q, row_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     och_q, och_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CH_NUM-1:0]   fifo_rdreq_c;
    logic                start_ok_c;
    logic                hs_c;

    // Lowest set bit index of a channel mask.
    function automatic logic [CH_W-1:0] lowest_ch(input logic [CH_NUM-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // Highest set bit index of a channel mask.
    function automatic logic [CH_W-1:0] highest_ch(input logic [CH_NUM-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // Next enabled index strictly above c (c itself if none).
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_NUM-1:0] m,
                                                input logic [CH_W-1:0]   c);
        logic [CH_W-1:0] r;
        r = c;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(c))) r = CH_W'(i);
        end
        return r;
    endfunction

    assign start_ok_c = Start && (Ch_Enable != '0) && (Frame_Len != '0);
    assign hs_c       = valid_q && Out_Ready;

    // Read strobe is issued in the READ cycle itself so q lands in LOAD.
    always_comb begin
        fifo_rdreq_c = '0;
        if (state_q == S_READ && !Fifo_Empty[ch_q]) begin
            fifo_rdreq_c[ch_q] = 1'b1;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        len_d   = len_q;
        row_d   = row_q;
        ch_d    = ch_q;
        data_d  = data_q;
        och_d   = och_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok_c) begin
                    mask_d  = Ch_Enable;
                    len_d   = Frame_Len;
                    row_d   = '0;
                    ch_d    = lowest_ch(Ch_Enable);
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // An empty FIFO stalls here; skipping would break the interleave.
                if (!Fifo_Empty[ch_q]) state_d = S_LOAD;
            end
            S_LOAD: begin
                data_d  = Fifo_Q[int'(ch_q)*DATA_W +: DATA_W];
                och_d   = ch_q;
                valid_d = 1'b1;
                last_d  = (row_q == (len_q - LEN_W'(1))) && (ch_q == highest_ch(mask_q));
                state_d = S_SEND;
            end
            S_SEND: begin
                if (hs_c) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (ch_q == highest_ch(mask_q)) begin
                        row_d   = row_q + LEN_W'(1);
                        ch_d    = lowest_ch(mask_q);
                        state_d = S_READ;
                    end else begin
                        ch_d    = next_ch(mask_q, ch_q);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any handshake; a word read this cycle is dropped.
        if (Abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            len_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            och_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            och_q   <= och_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Fifo_Rdreq = fifo_rdreq_c;
    assign Out_Data   = data_q;
    assign Out_Ch     = och_q;
    assign Out_Valid  = valid_q;
    assign Out_Last   = last_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_adc_capture_sched.sv
// Testbench for adc_capture_sched: directed frames against a transaction-level
// model (expected channel queue built from mask/len, FIFO word model, protocol
// rules) checked every cycle, plus hand-computed sample logs per scenario.
module tb_adc_capture_sched;

    localparam int unsigned CH_NUM = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned CH_W   = 2;

    logic                     Clk;
    logic                     Reset;
    logic                     Start;
    logic                     Abort;
    logic [CH_NUM-1:0]        Ch_Enable;
    logic [LEN_W-1:0]         Frame_Len;
    logic [CH_NUM-1:0]        Fifo_Empty;
    logic [CH_NUM*DATA_W-1:0] Fifo_Q;
    logic [CH_NUM-1:0]        Fifo_Rdreq;
    logic [DATA_W-1:0]        Out_Data;
    logic [CH_W-1:0]          Out_Ch;
    logic                     Out_Valid;
    logic                     Out_Ready;
    logic                     Out_Last;
    logic                     Busy;
    logic                     Done;

    adc_capture_sched #(
        .CH_NUM(CH_NUM), .DATA_W(DATA_W), .LEN_W(LEN_W), .CH_W(CH_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Ch_Enable(Ch_Enable), .Frame_Len(Frame_Len),
        .Fifo_Empty(Fifo_Empty), .Fifo_Q(Fifo_Q), .Fifo_Rdreq(Fifo_Rdreq),
        .Out_Data(Out_Data), .Out_Ch(Out_Ch), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Out_Last(Out_Last), .Busy(Busy), .Done(Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: word = {ch, read count}, presented the cycle after rdreq.
    logic [DATA_W-1:0] q_word [CH_NUM];
    int unsigned       rd_cnt [CH_NUM];

    always @(posedge Clk) begin
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (Reset) begin
                q_word[i] <= '0;
                rd_cnt[i] <= 0;
            end else if (Fifo_Rdreq[i]) begin
                q_word[i] <= DATA_W'((i << 6) | (rd_cnt[i] & 63));
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        Fifo_Q = '0;
        for (int i = 0; i < int'(CH_NUM); i++) Fifo_Q[i*DATA_W +: DATA_W] = q_word[i];
    end

    // Transaction model state.
    int           exp_q[$];
    logic [15:0]  hs_log[$];
    logic         m_busy = 1'b0;
    logic         done_exp = 1'b0;
    logic         rd1 = 1'b0, rd2 = 1'b0, prev_rd = 1'b0;
    logic         pv = 1'b0, pready = 1'b0, pabort = 1'b0, plast = 1'b0;
    logic [CH_W-1:0]   pch = '0;
    logic [DATA_W-1:0] pdata = '0;
    int           cyc = 0, start_cyc = 0, done_cyc = 0;
    logic         hs, legal;

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge Clk) begin
        cyc++;
        if (Reset) begin
            m_busy = 1'b0; done_exp = 1'b0; exp_q.delete();
            rd1 = 1'b0; rd2 = 1'b0; prev_rd = 1'b0; pv = 1'b0;
        end else begin
            chk("busy", 32'(Busy), 32'(m_busy));
            chk("done", 32'(Done), 32'(done_exp));
            if (done_exp) done_cyc = cyc;
            if (!m_busy) chk("idle_quiet", 32'({Out_Valid, Fifo_Rdreq}), 32'(0));
            if (Fifo_Rdreq != '0) begin
                legal = m_busy && (exp_q.size() > 0) && $onehot(Fifo_Rdreq) && !prev_rd && !Out_Valid;
                if (legal) legal = Fifo_Rdreq[exp_q[0]] && !Fifo_Empty[exp_q[0]];
                chk("rdreq_legal", 32'(legal), 32'(1));
            end
            if (rd2 && exp_q.size() > 0)
                chk("load_latency", 32'({Out_Valid, Out_Ch}), 32'({1'b1, CH_W'(exp_q[0])}));
            if (pv && !pready && !pabort)
                chk("hold", 32'({Out_Valid, Out_Last, Out_Ch, Out_Data}),
                    32'({1'b1, plast, pch, pdata}));
            if (Out_Valid && m_busy && exp_q.size() > 0)
                chk("out_last", 32'(Out_Last), 32'(exp_q.size() == 1));
            hs = m_busy && Out_Valid && Out_Ready && !Abort && (exp_q.size() > 0);
            if (hs) begin
                chk("out_ch", 32'(Out_Ch), 32'(exp_q[0]));
                chk("out_data", 32'(Out_Data), 32'(q_word[exp_q[0]]));
                hs_log.push_back({3'b0, Out_Last, 2'b00, Out_Ch, Out_Data});
                void'(exp_q.pop_front());
            end
            rd2 = rd1 && !Abort;
            rd1 = (Fifo_Rdreq != '0) && !Abort;
            prev_rd = (Fifo_Rdreq != '0);
            pv = Out_Valid; pready = Out_Ready; pabort = Abort;
            plast = Out_Last; pch = Out_Ch; pdata = Out_Data;
            if (done_exp) begin
                m_busy = 1'b0; done_exp = 1'b0;
            end else if (m_busy && Abort) begin
                m_busy = 1'b0; exp_q.delete();
            end else if (hs && exp_q.size() == 0) begin
                done_exp = 1'b1;
            end else if (!m_busy && Start && Ch_Enable != '0 && Frame_Len != '0) begin
                for (int r = 0; r < int'(Frame_Len); r++)
                    for (int c = 0; c < int'(CH_NUM); c++)
                        if (Ch_Enable[c]) exp_q.push_back(c);
                m_busy = 1'b1;
                start_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Start pulse, then scramble config to show it was latched.
    task automatic start_frame(input logic [CH_NUM-1:0] m, input int len);
        Ch_Enable = m;
        Frame_Len = LEN_W'(len);
        Start = 1'b1;
        tick(1);
        Start = 1'b0;
        Ch_Enable = ~m;
        Frame_Len = LEN_W'(len + 3);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (Busy && n < budget) begin
            tick(1);
            n++;
        end
        chk({nm, "_idle_timeout"}, 32'(Busy), 32'(0));
    endtask

    // Compare the handshake log with a hand-computed list (first entry at MSB).
    task automatic check_log(input string nm, input int n, input logic [127:0] e);
        chk({nm, "_count"}, 32'(hs_log.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < hs_log.size())
                chk($sformatf("%s_s%0d", nm, i), 32'(hs_log[i]), 32'(e[(n-1-i)*16 +: 16]));
    endtask

    initial begin
        int n;
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Ch_Enable = '0; Frame_Len = '0;
        Fifo_Empty = '0; Out_Ready = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_vals", 32'({Busy, Done, Out_Valid, Out_Last, Fifo_Rdreq, Out_Ch, Out_Data}), 32'(0));
        @(posedge Clk); #1;
        Reset = 1'b0;
        tick(2);

        // T1: all channels, two rows
        hs_log.delete();
        start_frame(4'b1111, 2);
        wait_idle("t1", 200);
        check_log("t1", 8, 128'({16'h0000, 16'h0140, 16'h0280, 16'h03C0,
                                 16'h0001, 16'h0141, 16'h0281, 16'h13C1}));
        chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'(25));

        // T2: sparse mask 1010, three rows
        hs_log.delete();
        start_frame(4'b1010, 3);
        wait_idle("t2", 200);
        check_log("t2", 6, 128'({16'h0142, 16'h03C2, 16'h0143, 16'h03C3, 16'h0144, 16'h13C4}));
        chk("t2_done_latency", 32'(done_cyc - start_cyc), 32'(19));

        // T3: channel 2 empty stalls the row
        hs_log.delete();
        Fifo_Empty = 4'b0100;
        start_frame(4'b1111, 1);
        n = 0;
        while (hs_log.size() < 2 && n < 50) begin tick(1); n++; end
        tick(10);
        chk("t3_stall", 32'({hs_log.size(), Fifo_Rdreq, Busy}), 32'({32'(2), 4'b0000, 1'b1}));
        Fifo_Empty = '0;
        wait_idle("t3", 200);
        check_log("t3", 4, 128'({16'h0002, 16'h0145, 16'h0282, 16'h13C5}));

        // T4: backpressure, plus Start while busy
        hs_log.delete();
        Out_Ready = 1'b0;
        start_frame(4'b0001, 2);
        n = 0;
        while (!Out_Valid && n < 20) begin tick(1); n++; end
        chk("t4_first", 32'({Out_Valid, Out_Ch, Out_Data}), 32'({1'b1, 2'd0, 8'h03}));
        tick(2);
        Ch_Enable = 4'b1111; Frame_Len = 12'd5; Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(2);
        chk("t4_held", 32'({Out_Valid, Out_Data, Busy}), 32'({1'b1, 8'h03, 1'b1}));
        Out_Ready = 1'b1;
        wait_idle("t4", 200);
        check_log("t4", 2, 128'({16'h0003, 16'h1004}));

        // T5: ignored starts (mask 0, len 0, during DONE)
        start_frame(4'b0000, 3);
        tick(3);
        chk("t5_mask0", 32'({Busy, Done, Fifo_Rdreq}), 32'(0));
        start_frame(4'b1111, 0);
        tick(3);
        chk("t5_len0", 32'({Busy, Done, Fifo_Rdreq}), 32'(0));
        hs_log.delete();
        start_frame(4'b0001, 1);
        tick(3);
        chk("t5_in_done", 32'({Busy, Done}), 32'(2'b11));
        Ch_Enable = 4'b1111; Frame_Len = 12'd2; Start = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(2);
        chk("t5_done_start", 32'({Busy, Done}), 32'(0));
        check_log("t5", 1, 128'({16'h1005}));

        // Abort coinciding with a READ strobe
        start_frame(4'b1111, 2);
        chk("abort_read_rdreq", 32'(Fifo_Rdreq), 32'(4'b0001));
        Abort = 1'b1;
        tick(1);
        Abort = 1'b0;
        chk("abort_read_idle", 32'({Busy, Out_Valid}), 32'(0));
        tick(2);

        // T6: abort during SEND of sample 3, with Ready high
        hs_log.delete();
        start_frame(4'b1111, 2);
        n = 0;
        while (hs_log.size() < 2 && n < 50) begin tick(1); n++; end
        Out_Ready = 1'b0;
        while (!Out_Valid && n < 60) begin tick(1); n++; end
        chk("t6_third", 32'({Out_Valid, Out_Ch}), 32'({1'b1, 2'd2}));
        Abort = 1'b1; Out_Ready = 1'b1;
        tick(1);
        Abort = 1'b0;
        chk("t6_abort", 32'({Busy, Out_Valid, Done}), 32'(0));
        tick(3);
        hs_log.delete();
        start_frame(4'b1111, 1);
        wait_idle("t6", 200);
        check_log("t6", 4, 128'({16'h0008, 16'h0147, 16'h0284, 16'h13C6}));

        // Reset mid-frame
        start_frame(4'b1111, 2);
        tick(4);
        Reset = 1'b1;
        tick(1);
        chk("midframe_reset", 32'({Busy, Done, Out_Valid, Out_Last, Out_Ch, Out_Data}), 32'(0));
        Reset = 1'b0;
        tick(3);
        chk("post_reset_idle", 32'({Busy, Fifo_Rdreq}), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
